// File: rtl/risc_pkg.sv
// Shared definitions for the 8-bit RISC controller and its memory responder.
//   - Default bus widths (address / data)
//   - Controller opcode encoding
//   - Responder FSM state encoding
package risc_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } resp_state_t;

endpackage

// File: rtl/risc_mem_responder_if.sv
// Controller <-> memory bus.
//   master (controller): drives rd, wr, addr, wdata; observes rdata,
//                        rdata_vld, ready, busy, err
//   slave  (responder) : the mirror image
interface risc_mem_responder_if
  import risc_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();

  logic          rd;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rdata_vld;
  logic          ready;
  logic          busy;
  logic          err;

  modport master (
    output rd, wr, addr, wdata,
    input  rdata, rdata_vld, ready, busy, err
  );

  modport slave (
    input  rd, wr, addr, wdata,
    output rdata, rdata_vld, ready, busy, err
  );

endinterface

// File: rtl/risc_mem_array.sv
// Single-port 2^AW x DW RAM: synchronous write, registered read
// (read-first on a same-address write). Contents are never reset.
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data of mem[addr] from the previous edge
module risc_mem_array #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/risc_mem_responder.sv
// Memory-side responder for the RISC controller bus strobes.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : slave side of the controller bus (rd/wr level strobes,
//                addr, wdata in; rdata, rdata_vld, ready, busy, err out)
//   prog_*     : side-band preload port, accepted only while idle
// Accesses are triggered by rising edges of rd/wr, complete after
// WAIT_CYCLES wait states, and are acknowledged by a one-cycle ready pulse.
module risc_mem_responder
  import risc_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  risc_mem_responder_if.slave  bus,
  input  logic                 prog_we,
  input  logic [AW-1:0]        prog_addr,
  input  logic [DW-1:0]        prog_wdata
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  resp_state_t   state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic          op_wr_reg, op_wr_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic          rdata_vld_reg, rdata_vld_next;
  logic          ready_reg, ready_next;
  logic          busy_reg, busy_next;
  logic          err_reg, err_next;
  logic          rd_q, wr_q;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic rd_req, wr_req;
  assign rd_req = bus.rd & ~rd_q;
  assign wr_req = bus.wr & ~wr_q;

  risc_mem_array #(.AW(AW), .DW(DW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      op_wr_reg     <= 1'b0;
      rdata_reg     <= '0;
      rdata_vld_reg <= 1'b0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      op_wr_reg     <= op_wr_next;
      rdata_reg     <= rdata_next;
      rdata_vld_reg <= rdata_vld_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
      err_reg       <= err_next;
      rd_q          <= bus.rd;
      wr_q          <= bus.wr;
    end
  end

  // The RAM read is registered, so the address that DONE consumes must be
  // presented one edge earlier: in IDLE the live bus address feeds the RAM
  // (captured on the request edge), afterwards the latched address does.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    op_wr_next     = op_wr_reg;
    rdata_next     = rdata_reg;
    rdata_vld_next = 1'b0;
    ready_next     = 1'b0;
    busy_next      = busy_reg;
    err_next       = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = addr_reg;
    mem_wdata      = wdata_reg;

    case (state_reg)
      IDLE: begin
        mem_addr = bus.addr;
        if (rd_req && wr_req) begin
          err_next = 1'b1;
        end else if (rd_req || wr_req) begin
          addr_next  = bus.addr;
          wdata_next = wr_req ? bus.wdata : wdata_reg;
          op_wr_next = wr_req;
          busy_next  = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = (WAIT_CYCLES == 0) ? DONE : WAIT;
        end
        // The program port only wins an otherwise quiet cycle.
        if (prog_we) begin
          if (rd_req || wr_req) begin
            err_next = 1'b1;
          end else begin
            mem_we    = 1'b1;
            mem_addr  = prog_addr;
            mem_wdata = prog_wdata;
          end
        end
      end

      WAIT: begin
        if (prog_we) err_next = 1'b1;
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      DONE: begin
        if (prog_we) err_next = 1'b1;
        ready_next = 1'b1;
        busy_next  = 1'b0;
        if (op_wr_reg) begin
          mem_we = 1'b1;
        end else begin
          rdata_next     = mem_rdata;
          rdata_vld_next = 1'b1;
        end
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign bus.rdata     = rdata_reg;
  assign bus.rdata_vld = rdata_vld_reg;
  assign bus.ready     = ready_reg;
  assign bus.busy      = busy_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_risc_mem_responder.sv
// Directed bench for risc_mem_responder: one instance with one wait state,
// one with zero wait states. Inputs change on the falling edge, outputs are
// observed on the falling edge.
module tb_risc_mem_responder;
  import risc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  risc_mem_responder_if #(.AW(5), .DW(8)) bus1 ();
  risc_mem_responder_if #(.AW(5), .DW(8)) bus0 ();

  logic       prog_we1, prog_we0;
  logic [4:0] prog_addr1, prog_addr0;
  logic [7:0] prog_wdata1, prog_wdata0;

  risc_mem_responder #(.AW(5), .DW(8), .WAIT_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus1),
    .prog_we    (prog_we1),
    .prog_addr  (prog_addr1),
    .prog_wdata (prog_wdata1)
  );

  risc_mem_responder #(.AW(5), .DW(8), .WAIT_CYCLES(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus0),
    .prog_we    (prog_we0),
    .prog_addr  (prog_addr0),
    .prog_wdata (prog_wdata0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic prog1(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we1 = 1'b1; prog_addr1 = a; prog_wdata1 = d;
    @(negedge clk);
    prog_we1 = 1'b0;
    $display("%0t prog1 addr=%h data=%h", $time, a, d);
  endtask

  task automatic prog0(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we0 = 1'b1; prog_addr0 = a; prog_wdata0 = d;
    @(negedge clk);
    prog_we0 = 1'b0;
    $display("%0t prog0 addr=%h data=%h", $time, a, d);
  endtask

  // One access on the one-wait-state instance. Latency is counted in falling
  // edges after the strobe is raised: request edge T, wait edge T+1,
  // completion edge T+2 -> ready seen at the third falling edge.
  task automatic acc1(input logic is_wr, input logic [4:0] a, input logic [7:0] d,
                      input string tag);
    int lat;
    @(negedge clk);
    bus1.addr = a; bus1.wdata = d;
    if (is_wr) bus1.wr = 1'b1; else bus1.rd = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus1.ready && lat < 20);
    check({tag, " ready"}, {31'd0, bus1.ready}, 32'd1);
    check({tag, " latency"}, lat, 32'd3);
    check({tag, " rdata_vld"}, {31'd0, bus1.rdata_vld}, {31'd0, !is_wr});
    if (!is_wr) check({tag, " rdata"}, {24'd0, bus1.rdata}, {24'd0, d});
    bus1.rd = 1'b0; bus1.wr = 1'b0;
    $display("%0t acc1 %s wr=%0d addr=%h data=%h lat=%0d", $time, tag, is_wr, a,
             is_wr ? d : bus1.rdata, lat);
  endtask

  typedef struct {
    logic       is_wr;
    logic [4:0] addr;
    logic [7:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs[7];

  initial begin
    int nready, nvld, nerr;

    vecs[0] = '{1'b1, 5'h10, 8'h01};
    vecs[1] = '{1'b1, 5'h11, 8'h80};
    vecs[2] = '{1'b0, 5'h10, 8'h01};
    vecs[3] = '{1'b0, 5'h11, 8'h80};
    vecs[4] = '{1'b0, 5'h1F, 8'h3C};
    vecs[5] = '{1'b0, 5'h03, 8'hA5};
    vecs[6] = '{1'b0, 5'h00, 8'h11};

    rst = 1'b1;
    bus1.rd = 0; bus1.wr = 0; bus1.addr = 0; bus1.wdata = 0;
    bus0.rd = 0; bus0.wr = 0; bus0.addr = 0; bus0.wdata = 0;
    prog_we1 = 0; prog_addr1 = 0; prog_wdata1 = 0;
    prog_we0 = 0; prog_addr0 = 0; prog_wdata0 = 0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("reset rdata", {24'd0, bus1.rdata}, 32'd0);
    check("reset busy", {31'd0, bus1.busy}, 32'd0);
    check("reset ready", {31'd0, bus1.ready}, 32'd0);
    check("reset err", {31'd0, bus1.err}, 32'd0);
    rst = 1'b0;

    prog1(5'h03, 8'hA5);
    prog1(5'h00, 8'h11);
    prog1(5'h02, 8'h5A);

    // Read with exact cycle-by-cycle timing
    @(negedge clk);
    bus1.addr = 5'h03; bus1.rd = 1'b1;
    @(negedge clk);
    check("rd T+0 ready", {31'd0, bus1.ready}, 32'd0);
    check("rd T+0 busy", {31'd0, bus1.busy}, 32'd1);
    @(negedge clk);
    check("rd T+1 ready", {31'd0, bus1.ready}, 32'd0);
    @(negedge clk);
    check("rd T+2 ready", {31'd0, bus1.ready}, 32'd1);
    check("rd T+2 vld", {31'd0, bus1.rdata_vld}, 32'd1);
    check("rd T+2 rdata", {24'd0, bus1.rdata}, 32'h0A5);
    bus1.rd = 1'b0;
    @(negedge clk);
    check("rd T+3 ready", {31'd0, bus1.ready}, 32'd0);
    check("rd T+3 vld", {31'd0, bus1.rdata_vld}, 32'd0);
    $display("%0t read addr=03 data=%h", $time, bus1.rdata);

    // Write with busy window
    @(negedge clk);
    bus1.addr = 5'h1F; bus1.wdata = 8'h3C; bus1.wr = 1'b1;
    @(negedge clk);
    check("wr T+0 busy", {31'd0, bus1.busy}, 32'd1);
    @(negedge clk);
    check("wr T+1 busy", {31'd0, bus1.busy}, 32'd1);
    check("wr T+1 ready", {31'd0, bus1.ready}, 32'd0);
    @(negedge clk);
    check("wr T+2 busy", {31'd0, bus1.busy}, 32'd0);
    check("wr T+2 ready", {31'd0, bus1.ready}, 32'd1);
    check("wr T+2 vld", {31'd0, bus1.rdata_vld}, 32'd0);
    bus1.wr = 1'b0;
    $display("%0t write addr=1F data=3C", $time);

    // Table-driven accesses
    for (int i = 0; i < 7; i++) begin
      acc1(vecs[i].is_wr, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
    end

    // Held strobe produces a single access
    @(negedge clk);
    bus1.addr = 5'h03; bus1.rd = 1'b1;
    nready = 0; nvld = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus1.ready) nready++;
      if (bus1.rdata_vld) nvld++;
      if (i == 5) bus1.rd = 1'b0;
    end
    check("held rd ready pulses", nready, 32'd1);
    check("held rd vld pulses", nvld, 32'd1);
    check("held rd busy after", {31'd0, bus1.busy}, 32'd0);
    check("held rd rdata", {24'd0, bus1.rdata}, 32'h0A5);
    $display("%0t held read ready_pulses=%0d", $time, nready);

    // Simultaneous rd and wr
    acc1(1'b0, 5'h00, 8'h11, "pre-conflict");
    @(negedge clk);
    bus1.addr = 5'h00; bus1.wdata = 8'hEE; bus1.rd = 1'b1; bus1.wr = 1'b1;
    @(negedge clk);
    check("conflict err", {31'd0, bus1.err}, 32'd1);
    check("conflict busy", {31'd0, bus1.busy}, 32'd0);
    nready = (bus1.ready) ? 1 : 0;
    nerr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus1.ready) nready++;
      if (bus1.err) nerr++;
    end
    check("conflict ready pulses", nready, 32'd0);
    check("conflict err one cycle", nerr, 32'd0);
    bus1.rd = 1'b0; bus1.wr = 1'b0;
    $display("%0t conflict rd+wr addr=00", $time);
    acc1(1'b0, 5'h00, 8'h11, "post-conflict");

    // Reset in the middle of a write
    @(negedge clk);
    bus1.addr = 5'h02; bus1.wdata = 8'hFF; bus1.wr = 1'b1;
    @(negedge clk);
    check("pre-rst busy", {31'd0, bus1.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst busy", {31'd0, bus1.busy}, 32'd0);
    check("async rst rdata", {24'd0, bus1.rdata}, 32'd0);
    check("async rst ready", {31'd0, bus1.ready}, 32'd0);
    check("async rst vld", {31'd0, bus1.rdata_vld}, 32'd0);
    check("async rst err", {31'd0, bus1.err}, 32'd0);
    bus1.wr = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    $display("%0t reset during write addr=02", $time);
    acc1(1'b0, 5'h02, 8'h5A, "after-rst");

    // Zero wait states, and program port while busy
    prog0(5'h04, 8'h77);
    @(negedge clk);
    bus0.addr = 5'h04; bus0.rd = 1'b1;
    @(negedge clk);
    check("w0 T+0 busy", {31'd0, bus0.busy}, 32'd1);
    check("w0 T+0 ready", {31'd0, bus0.ready}, 32'd0);
    prog_we0 = 1'b1; prog_addr0 = 5'h04; prog_wdata0 = 8'hEE;
    @(negedge clk);
    prog_we0 = 1'b0; bus0.rd = 1'b0;
    check("w0 T+1 ready", {31'd0, bus0.ready}, 32'd1);
    check("w0 T+1 vld", {31'd0, bus0.rdata_vld}, 32'd1);
    check("w0 T+1 rdata", {24'd0, bus0.rdata}, 32'h077);
    check("w0 busy prog err", {31'd0, bus0.err}, 32'd1);
    @(negedge clk);
    check("w0 err cleared", {31'd0, bus0.err}, 32'd0);
    check("w0 ready cleared", {31'd0, bus0.ready}, 32'd0);
    $display("%0t w0 read addr=04 data=%h with dropped prog", $time, bus0.rdata);
    @(negedge clk);
    bus0.addr = 5'h04; bus0.rd = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("w0 reread ready", {31'd0, bus0.ready}, 32'd1);
    check("w0 word unchanged", {24'd0, bus0.rdata}, 32'h077);
    bus0.rd = 1'b0;
    $display("%0t w0 reread addr=04 data=%h", $time, bus0.rdata);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
